// File: rtl/memory_map_fabric.sv
// memory_map_fabric: one master port fanned out to N_SLAVES memory-mapped
// slaves with address decode, per-slave acknowledge, timeout and error reply.
module memory_map_fabric #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_LSB = 16,
  parameter int SEL_BITS = 2,
  parameter int TIMEOUT = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_re,
  input  logic                         m_we,
  input  logic [ADDR_WIDTH-1:0]        m_addr,
  input  logic [DATA_WIDTH-1:0]        m_wdata,
  output logic [DATA_WIDTH-1:0]        m_rdata,
  output logic                         m_done,
  output logic                         m_err,
  output logic                         m_busy,
  output logic [N_SLAVES-1:0]          s_sel,
  output logic                         s_we,
  output logic [ADDR_WIDTH-1:0]        s_addr,
  output logic [DATA_WIDTH-1:0]        s_wdata,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]          s_ack
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [SEL_BITS:0] N_LIM = (SEL_BITS + 1)'(N_SLAVES);

  state_t state;
  logic [CW-1:0] cnt;

  logic [SEL_BITS-1:0] idx;
  logic [ADDR_WIDTH-1:0] addr_clr;
  logic [N_SLAVES-1:0] sel_dec;
  logic mapped;
  logic hit;
  logic expired;
  logic [DATA_WIDTH-1:0] rd_mux;

  // decode the request address and steer the selected slave's ack/data
  always_comb begin
    idx = m_addr[SEL_LSB +: SEL_BITS];
    addr_clr = m_addr;
    addr_clr[SEL_LSB +: SEL_BITS] = '0;
    mapped = ({1'b0, idx} < N_LIM);
    sel_dec = N_SLAVES'(1) << idx;
    hit = |(s_ack & s_sel);
    expired = (TIMEOUT > 0) && (cnt == TO_LAST);
    rd_mux = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (s_sel[k]) begin
        rd_mux = rd_mux | s_rdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // transaction FSM with registered master and slave side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      m_rdata <= '0;
      m_done  <= 1'b0;
      m_err   <= 1'b0;
      m_busy  <= 1'b0;
      s_sel   <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      m_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m_re | m_we) begin
            m_busy  <= 1'b1;
            s_addr  <= addr_clr;
            s_wdata <= m_wdata;
            if (mapped) begin
              state <= ACCESS;
              s_sel <= sel_dec;
              s_we  <= m_we;
            end else begin
              state  <= RESP;
              m_done <= 1'b1;
              m_err  <= 1'b1;
              if (!m_we) begin
                m_rdata <= ERR_DATA;
              end
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (hit) begin
            state  <= RESP;
            m_done <= 1'b1;
            m_err  <= 1'b0;
            s_sel  <= '0;
            s_we   <= 1'b0;
            if (!s_we) begin
              m_rdata <= rd_mux;
            end
          end else if (expired) begin
            state  <= RESP;
            m_done <= 1'b1;
            m_err  <= 1'b1;
            s_sel  <= '0;
            s_we   <= 1'b0;
            if (!s_we) begin
              m_rdata <= ERR_DATA;
            end
          end
        end
        RESP: begin
          state  <= IDLE;
          m_busy <= 1'b0;
          cnt    <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_map_fabric.sv
// tb_memory_map_fabric: randomized transactions against a transaction-level
// model; responses are queued at issue and checked by an independent monitor.
module tb_memory_map_fabric;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 3;
  localparam int SL = 16;
  localparam int SB = 2;
  localparam int TO = 16;
  localparam logic [DW-1:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  logic m_re, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic m_done, m_err, m_busy;
  logic [NS-1:0] s_sel;
  logic s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0] s_ack;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic err;
    logic [DW-1:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t got;
  logic [DW-1:0] last_rd;

  memory_map_fabric #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_SLAVES(NS),
    .SEL_LSB(SL), .SEL_BITS(SB), .TIMEOUT(TO), .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .rst(rst),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .m_err(m_err), .m_busy(m_busy),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // response monitor: every m_done must match the oldest expected response
  always @(negedge clk) begin
    if (!rst && m_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        got = exp_q.pop_front();
        chk("rsp_err", 64'(m_err), 64'(got.err));
        chk("rsp_rdata", 64'(m_rdata), 64'(got.rdata));
      end
    end
  end

  task automatic txn(input logic re, input logic we, input int idx,
                     input int waits, input bit junk);
    logic [AW-1:0] addr, sa;
    logic [DW-1:0] wd, rv;
    bit mapped, good;
    int acc, cyc;
    rsp_t e;
    addr = $urandom;
    addr[SL +: SB] = SB'(idx);
    sa = addr;
    sa[SL +: SB] = '0;
    wd = $urandom;
    rv = $urandom;
    mapped = (idx < NS);
    good = mapped && (waits < TO);
    acc = !mapped ? 0 : (good ? waits + 1 : TO);
    e.err = !good;
    e.rdata = we ? last_rd : (good ? rv : ERR);
    last_rd = e.rdata;
    exp_q.push_back(e);
    m_re = re;
    m_we = we;
    m_addr = addr;
    m_wdata = wd;
    @(negedge clk);
    m_re = 1'b0;
    m_we = 1'b0;
    cyc = 0;
    while (!m_done && cyc < 64) begin
      chk("busy_access", 64'(m_busy), 64'd1);
      if (mapped) begin
        chk("s_sel", 64'(s_sel), 64'(NS'(1) << idx));
        chk("s_we", 64'(s_we), 64'(we));
        chk("s_addr", 64'(s_addr), 64'(sa));
        chk("s_wdata", 64'(s_wdata), 64'(wd));
      end else begin
        chk("s_sel_decode", 64'(s_sel), 64'd0);
      end
      s_ack = NS'($urandom);
      s_rdata = {$urandom, $urandom, $urandom};
      if (mapped) begin
        s_ack[idx] = (cyc == waits);
        s_rdata[idx*DW +: DW] = rv;
      end
      if (junk) begin
        m_re = 1'($urandom);
        m_we = 1'($urandom);
        m_addr = $urandom;
        m_wdata = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    s_ack = '0;
    m_re = 1'b0;
    m_we = 1'b0;
    chk("access_cycles", 64'(cyc), 64'(acc));
    chk("busy_resp", 64'(m_busy), 64'd1);
    @(negedge clk);
    chk("idle_busy", 64'(m_busy), 64'd0);
    chk("idle_sel", 64'(s_sel), 64'd0);
    chk("idle_done", 64'(m_done), 64'd0);
    chk("rdata_hold", 64'(m_rdata), 64'(last_rd));
  endtask

  initial begin
    int k, w, op;
    rst = 1'b1;
    m_re = 1'b0;
    m_we = 1'b0;
    m_addr = '0;
    m_wdata = '0;
    s_rdata = '0;
    s_ack = '0;
    last_rd = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdata", 64'(m_rdata), 64'd0);
    chk("rst_done", 64'(m_done), 64'd0);
    chk("rst_err", 64'(m_err), 64'd0);
    chk("rst_busy", 64'(m_busy), 64'd0);
    chk("rst_sel", 64'(s_sel), 64'd0);
    chk("rst_we", 64'(s_we), 64'd0);
    chk("rst_addr", 64'(s_addr), 64'd0);
    chk("rst_wdata", 64'(s_wdata), 64'd0);

    txn(1'b1, 1'b0, 1, 0, 1'b0);
    txn(1'b0, 1'b1, 2, 3, 1'b0);
    txn(1'b1, 1'b0, 3, 0, 1'b0);
    txn(1'b0, 1'b1, 3, 0, 1'b0);
    txn(1'b1, 1'b0, 0, 100, 1'b0);
    txn(1'b1, 1'b0, 0, 15, 1'b0);
    txn(1'b0, 1'b1, 1, 16, 1'b0);
    txn(1'b1, 1'b1, 2, 1, 1'b1);
    txn(1'b1, 1'b0, 1, 2, 1'b1);

    m_re = 1'b1;
    m_addr = 32'h0001_0040;
    @(negedge clk);
    m_re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    chk("abort_sel", 64'(s_sel), 64'd0);
    chk("abort_busy", 64'(m_busy), 64'd0);
    chk("abort_done", 64'(m_done), 64'd0);
    chk("abort_rdata", 64'(m_rdata), 64'd0);
    repeat (4) @(negedge clk);
    txn(1'b1, 1'b0, 1, 1, 1'b0);

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 3);
      w = ($urandom % 8 == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
      op = $urandom % 3;
      txn(op != 1, op != 0, k, w, 1'($urandom));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
